// File: rtl/timer_pkg.sv
// Shared types and width helpers for the shared timer arbiter.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width for a modulus n, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DEF_CLK_DIV = 25000000;
  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned DEF_PRE_W   = $clog2(DEF_CLK_DIV);
  localparam int unsigned DEF_IDX_W   = $clog2(DEF_NUM_REQ);

endpackage

// File: rtl/tick_prescaler.sv
// Divide-by-CLK_DIV tick generator; synchronous clear wins over enable.
module tick_prescaler
  import timer_pkg::*;
#(
  parameter int unsigned CLK_DIV = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned     PS_W = cnt_w(CLK_DIV);
  localparam logic [PS_W-1:0] TC   = PS_W'(CLK_DIV - 1);

  logic [PS_W-1:0] cnt;

  assign tick = en && !clr && (cnt == TC);

  // Count 0..CLK_DIV-1 while enabled, wrapping on the tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      cnt <= '0;
    else if (clr)    cnt <= '0;
    else if (en)     cnt <= tick ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/shared_timer_arbiter.sv
// One prescaled countdown timer shared round-robin among NUM_REQ requesters.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | timer free; requests sampled, winner and duration latched
// RUN   | grant held by idx; count decrements once per tick
// DONE  | one-cycle done pulse to idx; pointer moves past idx
module shared_timer_arbiter
  import timer_pkg::*;
#(
  parameter int unsigned CLK_DIV = 25000000,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DUR_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*DUR_W-1:0] dur,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic [DUR_W-1:0]         remaining
);

  localparam int unsigned IDX_W = cnt_w(NUM_REQ);

  state_t             state, state_n;
  logic [IDX_W-1:0]   idx, idx_n, ptr, ptr_n, idx_inc;
  logic [DUR_W-1:0]   cnt, cnt_n;
  logic [IDX_W:0]     pick;
  logic               tick;
  logic [DUR_W-1:0]   dur_a [NUM_REQ];
  logic [NUM_REQ-1:0] idx_hot;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_dur
    assign dur_a[g] = dur[g*DUR_W +: DUR_W];
  end

  // First asserted request at or above p, wrapping; MSB flags a hit.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                             input logic [IDX_W-1:0]   p);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] j;
    res = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = IDX_W'((int'(p) + i) % NUM_REQ);
      if (r[j]) res = {1'b1, j};
    end
    return res;
  endfunction

  assign pick    = rr_pick(req, ptr);
  assign idx_inc = IDX_W'((int'(idx) + 1) % NUM_REQ);
  assign idx_hot = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;

  tick_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (state != RUN),
    .en    (state == RUN),
    .tick  (tick)
  );

  // State, holder index, tick count and round-robin pointer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
      ptr   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
      ptr   <= ptr_n;
    end
  end

  // Next-state logic: sample in IDLE, count ticks in RUN, cancel on req drop.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    ptr_n   = ptr;
    case (state)
      IDLE: begin
        if (pick[IDX_W]) begin
          idx_n   = pick[IDX_W-1:0];
          cnt_n   = dur_a[pick[IDX_W-1:0]];
          state_n = (cnt_n != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (!req[idx]) begin
          state_n = IDLE;
          ptr_n   = idx_inc;
          cnt_n   = '0;
        end else if (tick) begin
          cnt_n = cnt - 1'b1;
          if (cnt == DUR_W'(1)) state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
        ptr_n   = idx_inc;
        cnt_n   = '0;
      end
      default: state_n = IDLE;
    endcase
  end

  assign grant     = (state == RUN)  ? idx_hot : '0;
  assign done      = (state == DONE) ? idx_hot : '0;
  assign busy      = (state != IDLE);
  assign remaining = (state == RUN)  ? cnt : '0;

endmodule
